// File: rtl/lut_pkg.sv
// Shared definitions for the parameterised LUT: input mode encoding and
// the legal range of LUT input counts.
package lut_pkg;

    // Per-input evaluation mode, two bits per input in the TYPE vector.
    typedef enum logic [1:0] {
        LVL    = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        EITHER = 2'd3
    } mode_t;

    localparam int unsigned NUM_INP_MIN = 2;
    localparam int unsigned NUM_INP_MAX = 6;

endpackage : lut_pkg

// File: rtl/lut_param_if.sv
// Bus bundle for lut_param: LUT inputs, per-input modes, truth-table write
// port, output gate and the registered LUT output.
interface lut_param_if #(
    parameter int unsigned NUM_INP = 5,
    parameter int unsigned FUNC_W  = 32'd1 << NUM_INP
);
    logic                   enable_i;
    logic [NUM_INP-1:0]     inp_i;
    logic [2*NUM_INP-1:0]   TYPE;
    logic [FUNC_W-1:0]      FUNC;
    logic                   FUNC_WSTB;
    logic                   out_o;

    modport master (
        output enable_i, inp_i, TYPE, FUNC, FUNC_WSTB,
        input  out_o
    );

    modport slave (
        input  enable_i, inp_i, TYPE, FUNC, FUNC_WSTB,
        output out_o
    );
endinterface : lut_param_if

// File: rtl/lut_edge_sel.sv
// One LUT input: previous-value register plus the level/edge mode mux that
// produces this input's effective index bit.
module lut_edge_sel
    import lut_pkg::*;
(
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  inp_i,
    input  mode_t mode_i,
    output logic  e_o
);

    logic prev_q;
    logic prev_d;

    // The previous value tracks the input every cycle, independent of enable.
    always_comb begin
        prev_d = inp_i;
    end

    // Previous-value register, cleared asynchronously so the first edge after
    // reset sees an input that is already high as a rising edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Mode mux: level passes through, edge modes give a one-cycle pulse.
    always_comb begin
        e_o = 1'b0;
        unique case (mode_i)
            LVL:    e_o = inp_i;
            RISE:   e_o = inp_i & ~prev_q;
            FALL:   e_o = ~inp_i & prev_q;
            EITHER: e_o = inp_i ^ prev_q;
        endcase
    end

endmodule : lut_edge_sel

// File: rtl/lut_param.sv
// Parameterised registered LUT with per-input level/edge modes and a
// strobed truth-table register.
module lut_param
    import lut_pkg::*;
#(
    parameter int unsigned NUM_INP = 5,
    parameter int unsigned FUNC_W  = 32'd1 << NUM_INP
) (
    input  logic        clk_i,
    input  logic        reset_i,
    lut_param_if.slave  bus
);

    if ((NUM_INP < NUM_INP_MIN) || (NUM_INP > NUM_INP_MAX)) begin : g_bad_num_inp
        $error("lut_param: NUM_INP=%0d outside legal range %0d..%0d",
               NUM_INP, NUM_INP_MIN, NUM_INP_MAX);
    end

    if (FUNC_W != (32'd1 << NUM_INP)) begin : g_bad_func_w
        $error("lut_param: FUNC_W=%0d must equal 2**NUM_INP", FUNC_W);
    end

    logic [NUM_INP-1:0] e;
    logic [FUNC_W-1:0]  func_q;
    logic [FUNC_W-1:0]  func_d;
    logic               out_q;
    logic               out_d;

    for (genvar k = 0; k < NUM_INP; k++) begin : g_inp
        lut_edge_sel u_edge_sel (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .inp_i   (bus.inp_i[k]),
            .mode_i  (mode_t'(bus.TYPE[2*k +: 2])),
            .e_o     (e[k])
        );
    end

    // Truth table loads only on a strobe; the last strobe in a run wins.
    always_comb begin
        func_d = func_q;
        if (bus.FUNC_WSTB) begin
            func_d = bus.FUNC;
        end
    end

    // Output lookup uses the table currently held, so a table written in the
    // same cycle only affects the following evaluation.
    always_comb begin
        out_d = bus.enable_i & func_q[e];
    end

    // Table and output registers; reset dominates any coincident strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            func_q <= '0;
            out_q  <= 1'b0;
        end else begin
            func_q <= func_d;
            out_q  <= out_d;
        end
    end

    assign bus.out_o = out_q;

endmodule : lut_param
